vend_change_payout: RTL and testbench

- Change-payout sequencer for the act_vending machine.
- Accepts a change amount in units of 10 (the same encoding as act_vending's 5-bit chng output).
- Pays the amount out through a coin hopper using 50-coins first, then 10-coins, one coin per hopper handshake.
- Tracks 50-coin and 10-coin inventory, reports any shortfall, and faults on a hopper that does not respond.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_ack_timer.sv | 30 +++
 rtl/vend_change_payout.sv | 129 ++++++++++++
 tb/tb_vend_change_payout.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the change-payout sequencer.
// Coin values are expressed in units of 10, matching the requester's amount encoding.
package vend_pkg;

  localparam int unsigned AMT_W_DEF    = 5;
  localparam int unsigned INV_W_DEF    = 8;
  localparam int unsigned COIN50_UNITS = 5;
  localparam int unsigned COIN10_UNITS = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StEject,
    StWaitAck,
    StDone,
    StFault
  } state_e;

endpackage

// File: rtl/vend_ack_timer.sv
// Hopper acknowledge timer: cleared per coin, counts idle wait cycles and flags the cycle
// on which the count would reach ACK_TIMEOUT.
module vend_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // Saturates at ACK_TIMEOUT so a stalled hopper never wraps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CntW'(ACK_TIMEOUT))) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout_o = en_i && (cnt_q == CntW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/vend_change_payout.sv
// Change-payout sequencer: pays an amount (units of 10) through a coin hopper, 50-coins
// first, tracking coin inventory and reporting any unpaid remainder.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W       = AMT_W_DEF,
  parameter int unsigned INV_W       = INV_W_DEF,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  input  logic             hop_ack,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv50_in,
  input  logic [INV_W-1:0] inv10_in,
  output logic             eject50,
  output logic             eject10,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amt,
  output logic [INV_W-1:0] inv50,
  output logic [INV_W-1:0] inv10,
  output logic             fault
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q;
  logic             coin50_q, coin50_d;
  logic             accept, take50, take10, ack_ok, timeout;

  assign accept = (state_q == StIdle) && chg_valid && chg_ready;
  assign take50 = (remaining_q >= AMT_W'(COIN50_UNITS)) && (inv50 != '0);
  assign take10 = (remaining_q >= AMT_W'(COIN10_UNITS)) && (inv10 != '0);
  assign ack_ok = (state_q == StWaitAck) && hop_ack;

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == StEject),
    .en_i     ((state_q == StWaitAck) && !hop_ack),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d  = state_q;
    coin50_d = coin50_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StSel;
      StSel: begin
        if (remaining_q == '0) begin
          state_d = StDone;
        end else if (take50) begin
          state_d  = StEject;
          coin50_d = 1'b1;
        end else if (take10) begin
          state_d  = StEject;
          coin50_d = 1'b0;
        end else begin
          state_d = StDone;
        end
      end
      StEject:   state_d = StWaitAck;
      StWaitAck: begin
        if (hop_ack)      state_d = StSel;
        else if (timeout) state_d = StFault;
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      coin50_q    <= 1'b0;
      remaining_q <= '0;
      chg_ready   <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      eject50     <= 1'b0;
      eject10     <= 1'b0;
      done        <= 1'b0;
      short       <= 1'b0;
      short_amt   <= '0;
      inv50       <= '0;
      inv10       <= '0;
    end else begin
      state_q   <= state_d;
      coin50_q  <= coin50_d;
      chg_ready <= (state_d == StIdle);
      busy      <= (state_d != StIdle);
      fault     <= (state_d == StFault);
      eject50   <= (state_d == StEject) && coin50_d;
      eject10   <= (state_d == StEject) && !coin50_d;
      done      <= (state_d == StDone);
      if ((state_q == StIdle) && inv_load) begin
        inv50 <= inv50_in;
        inv10 <= inv10_in;
      end
      if (accept) begin
        remaining_q <= chg_amt;
        short       <= 1'b0;
        short_amt   <= '0;
      end
      if ((state_q == StSel) && (state_d == StDone)) begin
        short     <= (remaining_q != '0);
        short_amt <= remaining_q;
      end
      if (ack_ok) begin
        if (coin50_q) begin
          remaining_q <= remaining_q - AMT_W'(COIN50_UNITS);
          inv50       <= inv50 - INV_W'(1);
        end else begin
          remaining_q <= remaining_q - AMT_W'(COIN10_UNITS);
          inv10       <= inv10 - INV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vend_change_payout.sv
// Randomised scoreboard bench for vend_change_payout: expected payouts are computed from
// greedy coin arithmetic at issue time and compared by a monitor on each done pulse.
module tb_vend_change_payout;

  localparam int AMT_W       = 5;
  localparam int INV_W       = 8;
  localparam int ACK_TIMEOUT = 15;

  logic             clk, rst, chg_valid, chg_ready, hop_ack, inv_load;
  logic [AMT_W-1:0] chg_amt, short_amt;
  logic [INV_W-1:0] inv50_in, inv10_in, inv50, inv10;
  logic             eject50, eject10, busy, done, short, fault;

  vend_change_payout #(
    .AMT_W      (AMT_W),
    .INV_W      (INV_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .chg_valid(chg_valid),
    .chg_amt  (chg_amt),
    .chg_ready(chg_ready),
    .hop_ack  (hop_ack),
    .inv_load (inv_load),
    .inv50_in (inv50_in),
    .inv10_in (inv10_in),
    .eject50  (eject50),
    .eject10  (eject10),
    .busy     (busy),
    .done     (done),
    .short    (short),
    .short_amt(short_amt),
    .inv50    (inv50),
    .inv10    (inv10),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int short_f;
    int short_amt;
    int n50;
    int n10;
    int inv50;
    int inv10;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_inv50 = 0;
  int   m_inv10 = 0;
  bit   hop_en = 1'b0;
  int   cnt50 = 0;
  int   cnt10 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy payout: as many 50-coins as fit and are stocked, then 10-coins likewise.
  function automatic exp_t model(input int amt);
    exp_t e;
    int   rem;
    e.n50 = amt / 5;
    if (e.n50 > m_inv50) e.n50 = m_inv50;
    rem = amt - 5 * e.n50;
    e.n10 = (rem < m_inv10) ? rem : m_inv10;
    e.short_amt = rem - e.n10;
    e.short_f = (e.short_amt != 0) ? 1 : 0;
    m_inv50 -= e.n50;
    m_inv10 -= e.n10;
    e.inv50 = m_inv50;
    e.inv10 = m_inv10;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (chg_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // Returns one ns into the cycle after the accepting edge (the SEL cycle).
  task automatic issue(input int amt, input bit load, input int l50, input int l10,
                       input bit push);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    chg_valid = 1'b1;
    chg_amt   = AMT_W'(amt);
    inv_load  = load;
    inv50_in  = INV_W'(l50);
    inv10_in  = INV_W'(l10);
    if (load) begin
      m_inv50 = l50;
      m_inv10 = l10;
    end
    if (push) sb.push_back(model(amt));
    tick();
    chg_valid = 1'b0;
    inv_load  = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 600 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    tick();
  endtask

  task automatic wait_eject50(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eject50) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("eject50_timeout", 0, 1);
  endtask

  // Hopper model: acknowledges each eject 1..4 cycles later while enabled.
  initial begin
    hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hop_en && (eject50 || eject10)) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 hop_ack = 1'b1;
        @(posedge clk);
        #1 hop_ack = 1'b0;
      end
    end
  end

  // Monitor: counts coins and checks each completed payout against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (eject50 && eject10) check("eject_exclusive", 1, 0);
        if (eject50) cnt50++;
        if (eject10) cnt10++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("short", int'(short), e.short_f);
            check("short_amt", int'(short_amt), e.short_amt);
            check("n_eject50", cnt50, e.n50);
            check("n_eject10", cnt10, e.n10);
            check("inv50", int'(inv50), e.inv50);
            check("inv10", int'(inv10), e.inv10);
          end
          cnt50 = 0;
          cnt10 = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int seen;
    rst = 1'b0;
    chg_valid = 1'b0;
    chg_amt = '0;
    inv_load = 1'b0;
    inv50_in = '0;
    inv10_in = '0;
    repeat (2) tick();
    check("rst_ready", int'(chg_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_inv50", int'(inv50), 0);
    check("rst_fault", int'(fault), 0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", int'(chg_ready), 1);
    hop_en = 1'b1;

    // Load together with accept: the payout uses the freshly loaded counts.
    issue(7, 1'b1, 10, 10, 1'b1);
    check("t1_sel_no_eject", int'(eject50), 0);
    check("t1_busy", int'(busy), 1);
    tick();
    check("t1_first_eject50", int'(eject50), 1);
    drain();
    check("t1_inv50", int'(inv50), 9);
    check("t1_inv10", int'(inv10), 8);

    issue(0, 1'b0, 0, 0, 1'b1);
    check("zero_no_done_sel", int'(done), 0);
    tick();
    check("zero_done_t2", int'(done), 1);
    check("zero_no_eject", int'(eject50 | eject10), 0);
    drain();

    issue(7, 1'b1, 0, 3, 1'b1);
    drain();
    check("t3_short", int'(short), 1);
    check("t3_short_amt", int'(short_amt), 4);

    // inv_load while busy must not disturb the counters.
    issue(12, 1'b1, 10, 10, 1'b1);
    inv_load = 1'b1;
    inv50_in = INV_W'(20);
    inv10_in = INV_W'(20);
    repeat (8) tick();
    inv_load = 1'b0;
    drain();
    check("busy_load_inv50", int'(inv50), 8);
    check("busy_load_inv10", int'(inv10), 8);

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 10)), 1'b1);
    end
    drain();

    // Hopper never answers: FAULT after ACK_TIMEOUT cycles of waiting.
    hop_en = 1'b0;
    issue(5, 1'b1, 5, 5, 1'b0);
    wait_eject50(ok);
    n = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      tick();
      n++;
    end
    check("fault_latency", n, ACK_TIMEOUT + 1);
    check("fault_ready", int'(chg_ready), 0);
    check("fault_busy", int'(busy), 1);
    check("fault_inv50", int'(inv50), 5);
    chg_valid = 1'b1;
    chg_amt = AMT_W'(3);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eject50 || eject10 || done) seen++;
    end
    chg_valid = 1'b0;
    check("fault_ignores_req", seen, 0);
    check("fault_sticky", int'(fault), 1);

    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("recover_ready", int'(chg_ready), 1);
    check("recover_fault", int'(fault), 0);

    // Asynchronous reset while waiting for an ack aborts without a done pulse.
    issue(12, 1'b1, 10, 10, 1'b0);
    wait_eject50(ok);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_ready", int'(chg_ready), 0);
    check("async_inv50", int'(inv50), 0);
    check("async_inv10", int'(inv10), 0);
    check("async_eject", int'(eject50 | eject10), 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("post_rst_ready", int'(chg_ready), 1);
    check("post_rst_inv50", int'(inv50), 0);
    check("post_rst_inv10", int'(inv10), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
